// File: rtl/tone_sample_generator.sv
// Square-wave tone source feeding the AC97 sample FIFO, paced by FIFO-full backpressure.
// Optional write counter on sample_count is enabled with `define SAMPLE_COUNT_EN.
module tone_sample_generator #(
    parameter int unsigned SAMPLE_WIDTH = 20,
    parameter int unsigned PERIOD_WIDTH = 16
) (
    input  logic                    system_clock,
    input  logic                    system_reset_b,
    input  logic                    tone_enable,
    input  logic                    cfg_load,
    input  logic [PERIOD_WIDTH-1:0] tone_half_period,
    input  logic [3:0]              tone_amplitude,
    output logic [SAMPLE_WIDTH-1:0] sample_fifo_din,
    output logic                    sample_fifo_wr_en,
    input  logic                    sample_fifo_full,
    output logic                    busy,
    output logic [31:0]             sample_count
);

    localparam int unsigned SW = SAMPLE_WIDTH;
    localparam int unsigned PW = PERIOD_WIDTH;
    localparam int unsigned AW = 4;
    localparam int unsigned CW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   cnt_q, cnt_d;
    logic            phase_q, phase_d;
    logic [PW-1:0]   sh_period_q, sh_period_d;
    logic [AW-1:0]   sh_amp_q, sh_amp_d;
    logic [PW-1:0]   act_period_q, act_period_d;
    logic [AW-1:0]   act_amp_q, act_amp_d;
    logic [SW-1:0]   din_q, din_d;
    logic            busy_q, busy_d;
    logic            wr_en_c;
    logic            boundary_c;

    // Signed square-wave sample; a zero half-period means silence.
    function automatic logic [SW-1:0] sample_f(input logic [PW-1:0] period,
                                               input logic [AW-1:0] amp,
                                               input logic          neg);
        logic [SW-1:0] mag;
        mag = ((SW'(amp) + SW'(1)) << (SW - 5)) - SW'(1);
        if (period == '0) begin
            return '0;
        end
        return neg ? (~mag + SW'(1)) : mag;
    endfunction

    assign wr_en_c    = (state_q != IDLE) & ~sample_fifo_full;
    assign boundary_c = (act_period_q == '0) || (cnt_q == act_period_q - PW'(1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        phase_d      = phase_q;
        sh_period_d  = sh_period_q;
        sh_amp_d     = sh_amp_q;
        act_period_d = act_period_q;
        act_amp_d    = act_amp_q;
        din_d        = din_q;

        if (cfg_load) begin
            sh_period_d = tone_half_period;
            sh_amp_d    = tone_amplitude;
        end

        unique case (state_q)
            IDLE: begin
                din_d = '0;
                if (tone_enable) begin
                    state_d      = RUN;
                    cnt_d        = '0;
                    phase_d      = 1'b0;
                    act_period_d = sh_period_q;
                    act_amp_d    = sh_amp_q;
                    din_d        = sample_f(sh_period_q, sh_amp_q, 1'b0);
                end
            end
            RUN, FINISH: begin
                // Config is only swapped in at half-cycle boundaries, using the pre-load shadow.
                if (wr_en_c) begin
                    if (boundary_c) begin
                        cnt_d        = '0;
                        phase_d      = (act_period_q == '0) ? 1'b0 : ~phase_q;
                        act_period_d = sh_period_q;
                        act_amp_d    = sh_amp_q;
                        din_d        = sample_f(sh_period_q, sh_amp_q, phase_d);
                    end else begin
                        cnt_d = cnt_q + PW'(1);
                        din_d = sample_f(act_period_q, act_amp_q, phase_q);
                    end
                end

                if (wr_en_c && boundary_c && !tone_enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    din_d   = '0;
                end else if (!tone_enable) begin
                    state_d = FINISH;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                din_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge system_clock or negedge system_reset_b) begin
        if (!system_reset_b) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            phase_q      <= 1'b0;
            sh_period_q  <= '0;
            sh_amp_q     <= '0;
            act_period_q <= '0;
            act_amp_q    <= '0;
            din_q        <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            sh_period_q  <= sh_period_d;
            sh_amp_q     <= sh_amp_d;
            act_period_q <= act_period_d;
            act_amp_q    <= act_amp_d;
            din_q        <= din_d;
            busy_q       <= busy_d;
        end
    end

    assign sample_fifo_wr_en = wr_en_c;
    assign sample_fifo_din   = din_q;
    assign busy              = busy_q;

`ifdef SAMPLE_COUNT_EN
    logic [CW-1:0] count_q, count_d;

    // Free-running count of accepted writes; only reset clears it.
    assign count_d = wr_en_c ? (count_q + CW'(1)) : count_q;

    always_ff @(posedge system_clock or negedge system_reset_b) begin
        if (!system_reset_b) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign sample_count = count_q;
`else
    assign sample_count = CW'(0);
`endif

endmodule

// File: tb/tb_tone_sample_generator.sv
// Self-checking bench for tone_sample_generator: vector table, corner sequences, random run vs model.
module tb_tone_sample_generator;

    localparam int unsigned SW = 20;
    localparam int unsigned PW = 16;

    logic          clk;
    logic          rst_n;
    logic          tone_enable;
    logic          cfg_load;
    logic [PW-1:0] tone_half_period;
    logic [3:0]    tone_amplitude;
    logic [SW-1:0] sample_fifo_din;
    logic          sample_fifo_wr_en;
    logic          sample_fifo_full;
    logic          busy;
    logic [31:0]   sample_count;

    int n_cmp = 0;
    int n_err = 0;

    tone_sample_generator #(.SAMPLE_WIDTH(SW), .PERIOD_WIDTH(PW)) dut (
        .system_clock     (clk),
        .system_reset_b   (rst_n),
        .tone_enable      (tone_enable),
        .cfg_load         (cfg_load),
        .tone_half_period (tone_half_period),
        .tone_amplitude   (tone_amplitude),
        .sample_fifo_din  (sample_fifo_din),
        .sample_fifo_wr_en(sample_fifo_wr_en),
        .sample_fifo_full (sample_fifo_full),
        .busy             (busy),
        .sample_count     (sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected sample from amplitude arithmetic: mag = (amp+1)*2^(SW-5) - 1, negative via 2^SW - mag.
    function automatic logic [31:0] exp_sample(input int unsigned per, input int unsigned amp, input bit neg);
        int unsigned mag;
        mag = (amp + 1) * (32'd1 << (SW - 5)) - 1;
        if (per == 0) return 32'd0;
        return neg ? ((32'd1 << SW) - mag) : mag;
    endfunction

    task automatic do_reset();
        rst_n            = 1'b0;
        tone_enable      = 1'b0;
        cfg_load         = 1'b0;
        tone_half_period = '0;
        tone_amplitude   = '0;
        sample_fifo_full = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic cfg(input int unsigned per, input int unsigned amp);
        cfg_load         = 1'b1;
        tone_half_period = PW'(per);
        tone_amplitude   = 4'(amp);
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic stop_and_drain(input string name);
        int k;
        tone_enable      = 1'b0;
        sample_fifo_full = 1'b0;
        k = 0;
        while (busy && k < 200) begin
            tick();
            k++;
        end
        check({name, "_drained_busy"}, 32'(busy), 32'd0);
    endtask

    typedef struct packed {
        logic [15:0]      per;
        logic [3:0]       amp;
        logic [7:0][19:0] exp;   // exp[7] is the first write
    } vec_t;

    vec_t vecs[5];

    // Random-phase reference model: tone is alive until a half-cycle boundary write occurs with enable low.
    bit          m_alive;
    bit          m_neg;
    int unsigned m_pos, m_per, m_amp, m_sh_per, m_sh_amp;
    int unsigned m_count;

    task automatic model_step(input bit en, input bit full, input bit ld,
                              input int unsigned per_in, input int unsigned amp_in);
        int unsigned old_sp, old_sa;
        bit end_half;
        old_sp   = m_sh_per;
        old_sa   = m_sh_amp;
        end_half = 1'b0;
        if (ld) begin
            m_sh_per = per_in;
            m_sh_amp = amp_in;
        end
        if (!m_alive) begin
            if (en) begin
                m_alive = 1'b1;
                m_pos   = 0;
                m_neg   = 1'b0;
                m_per   = old_sp;
                m_amp   = old_sa;
            end
        end else begin
            if (!full) begin
                m_count++;
                if (m_per == 0 || m_pos + 1 == m_per) begin
                    end_half = 1'b1;
                    m_pos    = 0;
                    m_neg    = (m_per == 0) ? 1'b0 : !m_neg;
                    m_per    = old_sp;
                    m_amp    = old_sa;
                end else begin
                    m_pos++;
                end
            end
            if (end_half && !en) begin
                m_alive = 1'b0;
                m_pos   = 0;
                m_neg   = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] exp2 [4];
        int acc;
        int n;
        bit r_en, r_full, r_ld;
        int unsigned r_per, r_amp;

        // ---- vector table ----
        vecs[0].per = 16'd4; vecs[0].amp = 4'd15;
        vecs[0].exp = {20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h80001, 20'h80001, 20'h80001, 20'h80001};
        vecs[1].per = 16'd2; vecs[1].amp = 4'd0;
        vecs[1].exp = {20'h07FFF, 20'h07FFF, 20'hF8001, 20'hF8001, 20'h07FFF, 20'h07FFF, 20'hF8001, 20'hF8001};
        vecs[2].per = 16'd1; vecs[2].amp = 4'd7;
        vecs[2].exp = {20'h3FFFF, 20'hC0001, 20'h3FFFF, 20'hC0001, 20'h3FFFF, 20'hC0001, 20'h3FFFF, 20'hC0001};
        vecs[3].per = 16'd0; vecs[3].amp = 4'd3;
        vecs[3].exp = {20'h0, 20'h0, 20'h0, 20'h0, 20'h0, 20'h0, 20'h0, 20'h0};
        vecs[4].per = 16'd3; vecs[4].amp = 4'd1;
        vecs[4].exp = {20'h0FFFF, 20'h0FFFF, 20'h0FFFF, 20'hF0001, 20'hF0001, 20'hF0001, 20'h0FFFF, 20'h0FFFF};

        // ---- reset state ----
        rst_n = 1'b0; tone_enable = 1'b0; cfg_load = 1'b0;
        tone_half_period = '0; tone_amplitude = '0; sample_fifo_full = 1'b0;
        #3;
        check("reset_wr_en", 32'(sample_fifo_wr_en), 32'd0);
        check("reset_din", 32'(sample_fifo_din), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_count", sample_count, 32'd0);
        do_reset();

        for (int v = 0; v < 5; v++) begin
            cfg(vecs[v].per, vecs[v].amp);
            check("vec_idle_wr_en", 32'(sample_fifo_wr_en), 32'd0);
            tone_enable = 1'b1;
            tick();
            check("vec_busy", 32'(busy), 32'd1);
            for (int k = 0; k < 8; k++) begin
                check($sformatf("vec%0d_wr_en%0d", v, k), 32'(sample_fifo_wr_en), 32'd1);
                check($sformatf("vec%0d_din%0d", v, k), 32'(sample_fifo_din), 32'(vecs[v].exp[7 - k]));
                tick();
            end
            stop_and_drain($sformatf("vec%0d", v));
        end

        // ---- full toggling 1,0: accepted writes keep order, none while full ----
        exp2[0] = 32'h07FFF; exp2[1] = 32'h07FFF; exp2[2] = 32'hF8001; exp2[3] = 32'hF8001;
        cfg(2, 0);
        tone_enable = 1'b1;
        tick();
        acc = 0;
        for (int c = 0; c < 40 && acc < 8; c++) begin
            sample_fifo_full = (c % 2 == 0);
            #1;
            if (sample_fifo_full) begin
                check("full_no_write", 32'(sample_fifo_wr_en), 32'd0);
            end else begin
                check("full_drop_write", 32'(sample_fifo_wr_en), 32'd1);
                check($sformatf("full_din%0d", acc), 32'(sample_fifo_din), exp2[acc % 4]);
                acc++;
            end
            tick();
        end
        check("full_accepted", 32'(acc), 32'd8);
        stop_and_drain("full");

        // ---- stop after 2nd write completes the half-cycle ----
        cfg(5, 15);
        tone_enable = 1'b1;
        tick();
        check("stop_w1", 32'(sample_fifo_din), 32'h7FFFF);
        tick();
        check("stop_w2", 32'(sample_fifo_din), 32'h7FFFF);
        tick();
        tone_enable = 1'b0;
        n = 0;
        for (int c = 0; c < 20 && busy; c++) begin
            if (sample_fifo_wr_en) n++;
            tick();
        end
        check("stop_extra_writes", 32'(n), 32'd3);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_wr_en", 32'(sample_fifo_wr_en), 32'd0);

        // ---- mid half-cycle reconfig lands at next boundary ----
        cfg(4, 15);
        tone_enable = 1'b1;
        tick();
        check("recfg_w0", 32'(sample_fifo_din), 32'h7FFFF);
        cfg_load = 1'b1; tone_half_period = 16'd2; tone_amplitude = 4'd15;
        tick();
        cfg_load = 1'b0;
        for (int k = 1; k < 8; k++) begin
            check($sformatf("recfg_w%0d", k), 32'(sample_fifo_din),
                  (k < 4 || k >= 6) ? 32'h7FFFF : 32'h80001);
            tick();
        end
        stop_and_drain("recfg");

        // ---- period 0 silence, counter ----
        do_reset();
        check("p0_count_reset", sample_count, 32'd0);
        cfg(0, 9);
        tone_enable = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            check("p0_wr_en", 32'(sample_fifo_wr_en), 32'd1);
            check("p0_din", 32'(sample_fifo_din), 32'd0);
            tick();
        end
`ifdef SAMPLE_COUNT_EN
        check("p0_count", sample_count, 32'd6);
`else
        check("p0_count", sample_count, 32'd0);
`endif
        stop_and_drain("p0");

        // ---- async reset mid-tone, then restart ----
        cfg(3, 15);
        tone_enable = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_wr_en", 32'(sample_fifo_wr_en), 32'd0);
        check("arst_din", 32'(sample_fifo_din), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        tone_enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        cfg(3, 15);
        tone_enable = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("arst_restart%0d", k), 32'(sample_fifo_din), (k < 3) ? 32'h7FFFF : 32'h80001);
            tick();
        end
        stop_and_drain("arst");

        // ---- randomized run against the model ----
        do_reset();
        m_alive = 0; m_neg = 0; m_pos = 0; m_per = 0; m_amp = 0;
        m_sh_per = 0; m_sh_amp = 0; m_count = 0;
        r_en = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) r_en = !r_en;
            r_full = ($urandom_range(0, 3) == 0);
            r_ld   = ($urandom_range(0, 9) == 0);
            r_per  = $urandom_range(0, 5);
            r_amp  = $urandom_range(0, 15);
            tone_enable      = r_en;
            sample_fifo_full = r_full;
            cfg_load         = r_ld;
            tone_half_period = PW'(r_per);
            tone_amplitude   = 4'(r_amp);
            #1;
            check("rnd_busy", 32'(busy), 32'(m_alive));
            check("rnd_wr_en", 32'(sample_fifo_wr_en), 32'(m_alive && !r_full));
            if (m_alive && !r_full)
                check("rnd_din", 32'(sample_fifo_din), exp_sample(m_per, m_amp, m_neg));
            @(posedge clk);
            model_step(r_en, r_full, r_ld, r_per, r_amp);
            #1;
        end
        cfg_load = 1'b0;
`ifdef SAMPLE_COUNT_EN
        check("rnd_count", sample_count, m_count);
`else
        check("rnd_count", sample_count, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
